// File: rtl/rc_scheduler.sv
// rc_scheduler: round-robin shared XY route-compute pipeline for NUM_REQ head flits.
// Defining RC_SCHED_CHECK_EN adds an out-of-mesh destination check and the dest_err_o port.

package rc_scheduler_pkg;
   localparam int unsigned MESH_SIZE      = 4;
   localparam int unsigned DEST_ADDR_SIZE = 3;

   typedef enum logic [2:0] {
      CENTER = 3'd0,
      LEFT   = 3'd1,
      RIGHT  = 3'd2,
      UP     = 3'd3,
      DOWN   = 3'd4
   } port_t;
endpackage

module rc_unit
   import rc_scheduler_pkg::*;
#(
   parameter int unsigned X_CURRENT = MESH_SIZE / 2,
   parameter int unsigned Y_CURRENT = MESH_SIZE / 2
) (
   input  logic [DEST_ADDR_SIZE-1:0] x_dest_i,
   input  logic [DEST_ADDR_SIZE-1:0] y_dest_i,
   output port_t                     out_port_c
);
   localparam logic [DEST_ADDR_SIZE-1:0] X_CUR = DEST_ADDR_SIZE'(X_CURRENT);
   localparam logic [DEST_ADDR_SIZE-1:0] Y_CUR = DEST_ADDR_SIZE'(Y_CURRENT);

   // Dimension-ordered routing: resolve X completely before Y
   always_comb begin
      out_port_c = CENTER;
      if (x_dest_i < X_CUR) begin
         out_port_c = LEFT;
      end else if (x_dest_i > X_CUR) begin
         out_port_c = RIGHT;
      end else if (y_dest_i < Y_CUR) begin
         out_port_c = UP;
      end else if (y_dest_i > Y_CUR) begin
         out_port_c = DOWN;
      end
   end
endmodule

module rc_scheduler
   import rc_scheduler_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned X_CURRENT = MESH_SIZE / 2,
   parameter int unsigned Y_CURRENT = MESH_SIZE / 2
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_REQ-1:0]                       req_i,
   input  logic [NUM_REQ-1:0][DEST_ADDR_SIZE-1:0]   x_dest_i,
   input  logic [NUM_REQ-1:0][DEST_ADDR_SIZE-1:0]   y_dest_i,
   output logic [NUM_REQ-1:0]                       ack_o,
   output port_t                                    out_port_o,
   output logic                                     busy_o
`ifdef RC_SCHED_CHECK_EN
   ,
   output logic                                     dest_err_o
`endif
);
   localparam int unsigned       IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned       DW       = DEST_ADDR_SIZE;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);
`ifdef RC_SCHED_CHECK_EN
   localparam logic [DW-1:0]     MESH_LIM = DW'(MESH_SIZE);
`endif

   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic               s1_valid_q, s1_valid_d;
   logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
   logic [DW-1:0]      s1_x_q, s1_x_d;
   logic [DW-1:0]      s1_y_q, s1_y_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   port_t              out_port_q, out_port_d;
`ifdef RC_SCHED_CHECK_EN
   logic               dest_err_q, dest_err_d;
`endif

   logic [NUM_REQ-1:0] eligible_c;
   logic               grant_c;
   logic [IDX_W-1:0]   grant_idx_c;
   port_t              rc_port_c;

   rc_unit #(
      .X_CURRENT (X_CURRENT),
      .Y_CURRENT (Y_CURRENT)
   ) u_rc_unit (
      .x_dest_i   (s1_x_q),
      .y_dest_i   (s1_y_q),
      .out_port_c (rc_port_c)
   );

   // First eligible requester at or after ptr, wrapping; pending ones already hold a slot
   always_comb begin : grant_search
      int unsigned cand;
      eligible_c  = req_i & ~pending_q;
      grant_c     = 1'b0;
      grant_idx_c = '0;
      cand        = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = 32'(ptr_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!grant_c && eligible_c[IDX_W'(cand)]) begin
            grant_c     = 1'b1;
            grant_idx_c = IDX_W'(cand);
         end
      end
   end

   // Stage 1 capture; an ack in flight and a new grant always target different requesters
   always_comb begin
      ptr_d      = ptr_q;
      pending_d  = pending_q & ~ack_q;
      s1_valid_d = grant_c;
      s1_idx_d   = s1_idx_q;
      s1_x_d     = s1_x_q;
      s1_y_d     = s1_y_q;
      if (grant_c) begin
         ptr_d                  = (grant_idx_c == LAST_IDX) ? '0 : grant_idx_c + IDX_W'(1);
         pending_d[grant_idx_c] = 1'b1;
         s1_idx_d               = grant_idx_c;
         s1_x_d                 = x_dest_i[grant_idx_c];
         s1_y_d                 = y_dest_i[grant_idx_c];
      end
   end

   // Stage 2 result; out_port holds its last value when nothing completes
   always_comb begin
      ack_d      = '0;
      out_port_d = out_port_q;
`ifdef RC_SCHED_CHECK_EN
      dest_err_d = 1'b0;
`endif
      if (s1_valid_q) begin
         ack_d[s1_idx_q] = 1'b1;
         out_port_d      = rc_port_c;
`ifdef RC_SCHED_CHECK_EN
         if ((s1_x_q >= MESH_LIM) || (s1_y_q >= MESH_LIM)) begin
            out_port_d = CENTER;
            dest_err_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q      <= '0;
         pending_q  <= '0;
         s1_valid_q <= 1'b0;
         s1_idx_q   <= '0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         ack_q      <= '0;
         out_port_q <= CENTER;
`ifdef RC_SCHED_CHECK_EN
         dest_err_q <= 1'b0;
`endif
      end else begin
         ptr_q      <= ptr_d;
         pending_q  <= pending_d;
         s1_valid_q <= s1_valid_d;
         s1_idx_q   <= s1_idx_d;
         s1_x_q     <= s1_x_d;
         s1_y_q     <= s1_y_d;
         ack_q      <= ack_d;
         out_port_q <= out_port_d;
`ifdef RC_SCHED_CHECK_EN
         dest_err_q <= dest_err_d;
`endif
      end
   end

   assign ack_o      = ack_q;
   assign out_port_o = out_port_q;
   assign busy_o     = s1_valid_q;
`ifdef RC_SCHED_CHECK_EN
   assign dest_err_o = dest_err_q;
`endif

endmodule
